uart_fifo_tx: RTL and testbench
===============================

Name: uart_fifo_tx

Overview:
- UART transmitter that drains the 9-bit UART FIFO through its read port and serializes each byte as an 8N1 (or 8N2) frame on a single TX line.
- Sits between the outbound FIFO and the top-level TX pin.
- A one-deep holding register prefetches the next word while the current frame shifts out, so consecutive frames go out back-to-back with no idle gap.
- CTS-style flow control gates the start of each frame.

Parameters:
- CLKS_PER_BIT, 104, clock cycles per bit period (12 MHz / 115200); legal range is 2 or more.
- WIDTH, 9, FIFO word width. Bits [7:0] are the payload; bit 8 is carried but ignored.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- o_rd_en  out  1  FIFO read request; registered, one-cycle pulse
- i_rd_data  in  WIDTH  FIFO read data; valid in the cycle i_rd_valid is high
- i_rd_valid  in  1  FIFO read-data valid; arrives 1 cycle after the FIFO samples o_rd_en
- i_empty  in  1  FIFO empty flag
- i_cts  in  1  clear-to-send; 1 permits a new frame to start
- o_tx  out  1  serial output; idles high
- o_busy  out  1  high while a frame is on the line (START through the last STOP cycle)

Behaviour:
Reset values:
- o_tx=1, o_rd_en=0, o_busy=0.
- State IDLE; hold_valid=0; fetch_pending=0.
- Baud counter=0; bit index=0.

Reset mid-frame:
- o_tx returns to 1 on the next edge.
- The frame is aborted; a held or in-flight word is dropped.
- FIFO contents are untouched, because the FIFO has its own reset.

Prefetch:
- o_rd_en is registered. It is set for exactly one cycle when i_empty=0, hold_valid=0, fetch_pending=0 and o_rd_en=0.
- Setting o_rd_en sets fetch_pending.
- On the cycle after o_rd_en: if i_rd_valid=1, then hold_data <= i_rd_data[7:0] and hold_valid <= 1. In either case fetch_pending clears.
- i_rd_valid=0 (empty race) is not an error; it only means no word was obtained.
- Prefetch runs in every state, so at most one word is held and at most one read is outstanding.

State machine (IDLE, START, DATA, STOP):
- IDLE: o_tx=1. If hold_valid and i_cts, go to START.
  - Load shift register from hold_data.
  - Clear hold_valid in the same cycle. A prefetch may then issue on the next cycle.
- START: o_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: o_tx=shift[0], LSB first, each bit for CLKS_PER_BIT cycles. Shift right after each bit. After bit 7, go to STOP.
- STOP: o_tx=1 for STOP_BITS*CLKS_PER_BIT cycles. In the final cycle:
  - If hold_valid and i_cts: go straight to START and load the next word. The stop bit is followed immediately by a start bit, with no idle gap.
  - Otherwise go to IDLE.
- o_tx is driven from a register. The first start-bit cycle appears 1 cycle after the IDLE-to-START decision.

Flow control:
- i_cts is sampled only at frame-start decisions.
- Deasserting i_cts mid-frame does not truncate the frame.

Baud counter:
- $clog2(CLKS_PER_BIT) bits.
- Loaded with CLKS_PER_BIT-1 on entry to each bit, decremented each cycle.
- The bit ends when the counter reaches 0. No wrap arithmetic is relied upon.

Frame timing:
- A frame lasts exactly (1+8+STOP_BITS)*CLKS_PER_BIT cycles.
- From a non-empty FIFO and idle state, the first start bit appears within 4 cycles.

Decomposition:
- Package uart_pkg holds:
  - typedef enum tx_state_t {IDLE, START, DATA, STOP};
  - localparam DATA_BITS=8;
  - localparam UART_WORD_W=9.
- Natural sub-module: uart_baud_tick (loadable down-counter with terminal-count output). The FSM, prefetch logic and shift register stay in uart_fifo_tx.

Test Plan:
- CLKS_PER_BIT=4, FIFO holds 0x55, i_cts=1 -> expected response:
  - o_rd_en pulses once;
  - o_tx low for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each;
  - then high for 4 cycles; o_busy high for exactly 40 cycles.
- FIFO preloaded with 0xA3, 0x0F, 0xFF -> three frames with no idle cycles between them. The start bit directly follows each stop bit, and the frames total 120 cycles of o_busy.
- i_cts=0 with FIFO non-empty -> expected response:
  - one prefetch occurs and o_tx stays 1;
  - raising i_cts starts the frame 1 cycle later;
  - dropping i_cts mid-frame still completes the frame.
- Empty-race case: force i_rd_valid=0 after an o_rd_en -> no frame, o_tx=1, and o_rd_en re-issues only while i_empty=0.
- Assert i_rst during DATA bit 3 -> o_tx=1, o_busy=0 and o_rd_en=0 on the next edge. The held word is dropped, and the next FIFO word transmits normally after reset is released.
- STOP_BITS=2, byte 0x80 -> stop high for 8 cycles and total frame 44 cycles; bit 7 is the last data bit and is 1.

Source files
------------

// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// Module   : uart_pkg
// Brief    : Shared types and constants for the UART transmit path.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

    localparam int DATA_BITS   = 8;
    localparam int UART_WORD_W = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
//------------------------------------------------------------------------------
// Module   : uart_baud_tick
// Brief    : Loadable bit-period down-counter; o_tick marks the last cycle.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    output logic o_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] r_cnt;

    // Counter saturates at zero, so no wrap behaviour is ever exercised.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CNT_W'(CLKS_PER_BIT - 1);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tick = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/uart_fifo_tx.sv
//------------------------------------------------------------------------------
// Module   : uart_fifo_tx
// Brief    : FIFO-fed 8N1/8N2 UART transmitter with one-word prefetch and CTS.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_fifo_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int WIDTH        = 9,
    parameter int STOP_BITS    = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic             o_rd_en,
    input  logic [WIDTH-1:0] i_rd_data,
    input  logic             i_rd_valid,
    input  logic             i_empty,
    input  logic             i_cts,
    output logic             o_tx,
    output logic             o_busy
);

    tx_state_t        r_state;
    logic [7:0]       r_hold_data;
    logic [7:0]       r_shift;
    logic             r_hold_valid;
    logic             r_fetch_pending;
    logic [2:0]       r_bit_idx;
    logic             w_tick;
    logic             w_launch;
    logic             w_load;
    logic             w_unused_msb;

    assign w_launch     = r_hold_valid && i_cts;
    // In IDLE the counter is only reloaded when a frame actually launches.
    assign w_load       = (r_state == IDLE) ? w_launch : w_tick;
    assign w_unused_msb = ^i_rd_data[WIDTH-1:DATA_BITS];

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (w_load),
        .o_tick (w_tick)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state         <= IDLE;
            r_hold_data     <= '0;
            r_shift         <= '0;
            r_hold_valid    <= 1'b0;
            r_fetch_pending <= 1'b0;
            r_bit_idx       <= '0;
            o_rd_en         <= 1'b0;
            o_tx            <= 1'b1;
            o_busy          <= 1'b0;
        end else begin
            o_rd_en <= 1'b0;
            if (!i_empty && !r_hold_valid && !r_fetch_pending && !o_rd_en) begin
                o_rd_en         <= 1'b1;
                r_fetch_pending <= 1'b1;
            end
            // Read data returns the cycle after the request pulse; an empty race yields nothing.
            if (r_fetch_pending && !o_rd_en) begin
                r_fetch_pending <= 1'b0;
                if (i_rd_valid) begin
                    r_hold_data  <= i_rd_data[DATA_BITS-1:0];
                    r_hold_valid <= 1'b1;
                end
            end

            case (r_state)
                IDLE: begin
                    o_tx   <= 1'b1;
                    o_busy <= 1'b0;
                    if (w_launch) begin
                        r_state      <= START;
                        r_shift      <= r_hold_data;
                        r_hold_valid <= 1'b0;
                        r_bit_idx    <= '0;
                        o_tx         <= 1'b0;
                        o_busy       <= 1'b1;
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_state   <= DATA;
                        r_bit_idx <= '0;
                        o_tx      <= r_shift[0];
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_bit_idx == 3'(DATA_BITS - 1)) begin
                            r_state   <= STOP;
                            r_bit_idx <= '0;
                            o_tx      <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_shift   <= r_shift >> 1;
                            o_tx      <= r_shift[1];
                        end
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        if (r_bit_idx != 3'(STOP_BITS - 1)) begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end else if (w_launch) begin
                            // Back-to-back: the next start bit follows the stop bit directly.
                            r_state      <= START;
                            r_shift      <= r_hold_data;
                            r_hold_valid <= 1'b0;
                            r_bit_idx    <= '0;
                            o_tx         <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                            o_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    o_tx    <= 1'b1;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_fifo_tx.sv
//------------------------------------------------------------------------------
// Module   : tb_uart_fifo_tx
// Brief    : Scoreboard bench: FIFO models feed two transmitters, a line decoder checks frames.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_fifo_tx;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       rd_en0, rvalid0 = 1'b0, empty0, cts0 = 1'b0, tx0, busy0;
    logic       rd_en1, rvalid1 = 1'b0, empty1, cts1 = 1'b0, tx1, busy1;
    logic [8:0] rdata0 = '0, rdata1 = '0;

    uart_fifo_tx #(.CLKS_PER_BIT(CPB), .WIDTH(9), .STOP_BITS(1)) dut0 (
        .i_clk(clk), .i_rst(rst), .o_rd_en(rd_en0), .i_rd_data(rdata0),
        .i_rd_valid(rvalid0), .i_empty(empty0), .i_cts(cts0), .o_tx(tx0), .o_busy(busy0));

    uart_fifo_tx #(.CLKS_PER_BIT(CPB), .WIDTH(9), .STOP_BITS(2)) dut1 (
        .i_clk(clk), .i_rst(rst), .o_rd_en(rd_en1), .i_rd_data(rdata1),
        .i_rd_valid(rvalid1), .i_empty(empty1), .i_cts(cts1), .o_tx(tx1), .o_busy(busy1));

    // FIFO models: words written by the stimulus, popped on the request pulse.
    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    int         push0 = 0, pop0 = 0, push1 = 0, pop1 = 0;
    logic       race0 = 1'b0;
    logic [7:0] exp0 [$];
    logic [7:0] exp1 [$];

    assign empty0 = (push0 == pop0);
    assign empty1 = (push1 == pop1);

    always @(posedge clk) begin
        rvalid0 <= 1'b0;
        rvalid1 <= 1'b0;
        if (rd_en0 && push0 != pop0) begin
            pop0 <= pop0 + 1;
            if (!race0) begin
                rvalid0 <= 1'b1;
                rdata0  <= {1'b1, mem0[pop0 % 256]};
            end
        end
        if (rd_en1 && push1 != pop1) begin
            pop1    <= pop1 + 1;
            rvalid1 <= 1'b1;
            rdata1  <= {1'b1, mem1[pop1 % 256]};
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Line decoder state and activity counters, one slot per DUT.
    logic       act [2] = '{1'b0, 1'b0};
    int         pos [2] = '{0, 0};
    logic [7:0] byt [2];
    int         bad [2] = '{0, 0};
    int         frames [2] = '{0, 0};
    int         bad_idle = 0;
    int         busy_cnt [2], rd_cnt [2], low_cnt [2], first_b [2], last_b [2];
    int         cyc = 0;

    task automatic mon_step(input int d, input logic tx, input logic busy);
        int slot, sub, flen;
        logic [7:0] e;
        flen = (d == 0) ? CPB * 10 : CPB * 11;
        if (rst) begin
            act[d] = 1'b0;
        end else begin
            if (!act[d] && tx == 1'b0) begin
                act[d] = 1'b1;
                pos[d] = 0;
                bad[d] = 0;
                byt[d] = '0;
            end else if (!act[d] && busy) begin
                bad_idle++;
            end
            if (act[d]) begin
                slot = pos[d] / CPB;
                sub  = pos[d] % CPB;
                if (!busy) bad[d]++;
                if (slot == 0) begin
                    if (tx !== 1'b0) bad[d]++;
                end else if (slot <= 8) begin
                    if (sub == 0) byt[d][slot-1] = tx;
                    else if (tx !== byt[d][slot-1]) bad[d]++;
                end else if (tx !== 1'b1) begin
                    bad[d]++;
                end
                pos[d]++;
                if (pos[d] == flen) begin
                    act[d] = 1'b0;
                    frames[d]++;
                    if (d == 0) begin
                        check_eq("sb0_nonempty", exp0.size() > 0, 1);
                        if (exp0.size() > 0) begin
                            e = exp0.pop_front();
                            check_eq("frame_byte0", byt[d], e);
                        end
                    end else begin
                        check_eq("sb1_nonempty", exp1.size() > 0, 1);
                        if (exp1.size() > 0) begin
                            e = exp1.pop_front();
                            check_eq("frame_byte1", byt[d], e);
                        end
                    end
                    check_eq("frame_shape", bad[d], 0);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon_step(0, tx0, busy0);
        mon_step(1, tx1, busy1);
        if (busy0) begin busy_cnt[0]++; if (first_b[0] < 0) first_b[0] = cyc; last_b[0] = cyc; end
        if (busy1) begin busy_cnt[1]++; if (first_b[1] < 0) first_b[1] = cyc; last_b[1] = cyc; end
        if (rd_en0) rd_cnt[0]++;
        if (rd_en1) rd_cnt[1]++;
        if (tx0 == 1'b0) low_cnt[0]++;
        if (tx1 == 1'b0) low_cnt[1]++;
        cyc++;
    end

    task automatic clear_counts();
        for (int d = 0; d < 2; d++) begin
            busy_cnt[d] = 0; rd_cnt[d] = 0; low_cnt[d] = 0; first_b[d] = -1; last_b[d] = -1;
        end
    endtask

    task automatic push(input int d, input logic [7:0] b, input bit expect_out);
        if (d == 0) begin
            mem0[push0 % 256] = b;
            push0++;
            if (expect_out) exp0.push_back(b);
        end else begin
            mem1[push1 % 256] = b;
            push1++;
            if (expect_out) exp1.push_back(b);
        end
    endtask

    task automatic wait_frames(input int d, input int n, input int budget);
        int k;
        k = 0;
        while (frames[d] < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_eq("frame_timeout", frames[d] >= n, 1);
    endtask

    initial begin
        int k;
        clear_counts();
        repeat (3) @(negedge clk);
        check_eq("rst_tx", tx0, 1);
        check_eq("rst_busy", busy0, 0);
        check_eq("rst_rd_en", rd_en0, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single 0x55 frame
        clear_counts();
        cts0 = 1'b1;
        push(0, 8'h55, 1);
        k = 0;
        while (tx0 !== 1'b0 && k < 10) begin @(negedge clk); k++; end
        check_eq("start_latency", (k >= 1 && k <= 4), 1);
        wait_frames(0, 1, 100);
        repeat (5) @(negedge clk);
        check_eq("single_rd_pulses", rd_cnt[0], 1);
        check_eq("single_busy", busy_cnt[0], 40);

        // CTS gating
        cts0 = 1'b0;
        clear_counts();
        push(0, 8'h81, 1);
        repeat (20) @(negedge clk);
        check_eq("cts_rd_pulses", rd_cnt[0], 1);
        check_eq("cts_tx_low", low_cnt[0], 0);
        check_eq("cts_busy", busy_cnt[0], 0);
        cts0 = 1'b1;
        @(negedge clk);
        check_eq("cts_start", tx0, 0);
        repeat (10) @(negedge clk);
        cts0 = 1'b0;
        wait_frames(0, 2, 100);
        check_eq("cts_full_frame", busy_cnt[0], 40);

        // Back-to-back frames from a preloaded FIFO
        push(0, 8'hA3, 1);
        push(0, 8'h0F, 1);
        push(0, 8'hFF, 1);
        repeat (10) @(negedge clk);
        clear_counts();
        cts0 = 1'b1;
        wait_frames(0, 5, 300);
        repeat (5) @(negedge clk);
        check_eq("b2b_busy", busy_cnt[0], 120);
        check_eq("b2b_span", last_b[0] - first_b[0] + 1, 120);

        // Empty race: the read returns nothing and the FIFO is then empty
        clear_counts();
        race0 = 1'b1;
        push(0, 8'h99, 0);
        repeat (20) @(negedge clk);
        check_eq("race_rd_pulses", rd_cnt[0], 1);
        check_eq("race_tx_low", low_cnt[0], 0);
        check_eq("race_busy", busy_cnt[0], 0);
        race0 = 1'b0;
        push(0, 8'h3C, 1);
        wait_frames(0, 6, 100);
        check_eq("race_recover_rd", rd_cnt[0], 2);

        // Reset during data bit 3 with a second word held
        push(0, 8'h5A, 0);
        push(0, 8'hC3, 0);
        k = 0;
        while (!(act[0] && (pos[0] - 1) / CPB == 4) && k < 100) begin @(negedge clk); k++; end
        check_eq("reach_bit3", k < 100, 1);
        push(0, 8'hE7, 1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_tx", tx0, 1);
        check_eq("midrst_busy", busy0, 0);
        check_eq("midrst_rd_en", rd_en0, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_frames(0, 7, 200);
        repeat (10) @(negedge clk);
        check_eq("midrst_sb_drained", exp0.size(), 0);

        // Two stop bits
        clear_counts();
        cts1 = 1'b1;
        push(1, 8'h80, 1);
        wait_frames(1, 1, 200);
        repeat (5) @(negedge clk);
        check_eq("stop2_busy", busy_cnt[1], 44);
        check_eq("idle_busy", bad_idle, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
